// File: rtl/amber_wb_responder.sv
// Wishbone-classic 128-bit slave memory for the Amber core, with programmable
// wait states, byte-lane writes, out-of-range bus errors and a full-line preload port.
module amber_wb_responder #(
    parameter int          DEPTH_LOG2  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_wb_adr,
    input  logic [15:0]           i_wb_sel,
    input  logic                  i_wb_we,
    input  logic [127:0]          i_wb_dat,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    output logic [127:0]          o_wb_dat,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    input  logic                  i_ld_en,
    input  logic [DEPTH_LOG2-1:0] i_ld_idx,
    input  logic [127:0]          i_ld_dat,
    output logic                  o_busy
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN = 33'd16 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    adr_q;
    logic [15:0]    sel_q;
    logic           we_q;
    logic [127:0]   wdat_q;
    logic [127:0]   rdat_q, rdat_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [127:0]   mem [DEPTH];

    logic                  req;
    logic                  idle;
    logic                  go_resp;
    logic [31:0]           acc_adr;
    logic [15:0]           acc_sel;
    logic                  acc_we;
    logic [127:0]          acc_dat;
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] line;
    logic                  wr_en;

    assign req  = i_wb_cyc & i_wb_stb;
    assign idle = (state_q == S_IDLE);

    // With zero wait states the access happens on the accepting edge itself,
    // so the live bus values are used instead of the not-yet-latched copies.
    assign acc_adr = idle ? i_wb_adr : adr_q;
    assign acc_sel = idle ? i_wb_sel : sel_q;
    assign acc_we  = idle ? i_wb_we  : we_q;
    assign acc_dat = idle ? i_wb_dat : wdat_q;

    assign off      = acc_adr - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign line     = off[DEPTH_LOG2+3:4];
    assign wr_en    = go_resp & acc_we & in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_resp) begin
            ack_d = in_range;
            err_d = ~in_range;
            if (in_range && !acc_we) rdat_d = mem[line];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (idle && req) begin
                adr_q  <= i_wb_adr;
                sel_q  <= i_wb_sel;
                we_q   <= i_wb_we;
                wdat_q <= i_wb_dat;
            end
        end
    end

    // Bus write is ordered after the preload so its selected lanes win on a collision.
    always_ff @(posedge i_clk) begin
        if (i_ld_en) mem[i_ld_idx] <= i_ld_dat;
        if (wr_en) begin
            for (int b = 0; b < 16; b++) begin
                if (acc_sel[b]) mem[line][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    assign o_wb_dat = rdat_q;
    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;
    assign o_busy   = ~idle;

endmodule

// File: tb/tb_amber_wb_responder.sv
// Self-checking bench: a per-cycle expectation schedule built from a line-array
// memory model, compared against the responder every cycle, plus directed literals.
module tb_amber_wb_responder;

    localparam int          DL    = 8;
    localparam int          WS    = 2;
    localparam int          DEPTH = 1 << DL;
    localparam int          NCYC  = 16384;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   i_wb_adr = '0;
    logic [15:0]   i_wb_sel = '0;
    logic          i_wb_we = 1'b0;
    logic [127:0]  i_wb_dat = '0;
    logic          i_wb_cyc = 1'b0;
    logic          i_wb_stb = 1'b0;
    logic [127:0]  o_wb_dat;
    logic          o_wb_ack;
    logic          o_wb_err;
    logic          i_ld_en = 1'b0;
    logic [DL-1:0] i_ld_idx = '0;
    logic [127:0]  i_ld_dat = '0;
    logic          o_busy;

    amber_wb_responder #(
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wb_adr(i_wb_adr),
        .i_wb_sel(i_wb_sel),
        .i_wb_we (i_wb_we),
        .i_wb_dat(i_wb_dat),
        .i_wb_cyc(i_wb_cyc),
        .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat),
        .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err),
        .i_ld_en (i_ld_en),
        .i_ld_idx(i_ld_idx),
        .i_ld_dat(i_ld_dat),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    bit [127:0] mmem    [DEPTH];
    bit         exp_ack [NCYC];
    bit         exp_err [NCYC];
    bit         exp_busy[NCYC];
    bit [127:0] exp_dat [NCYC];

    int           n_vec = 0;
    int           n_bad = 0;
    bit           chk_on = 1'b0;
    int           ack_cyc[$];
    int           err_cnt = 0;
    logic [127:0] last_rd = '0;

    task automatic chkw(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chkb(string nm, logic act, logic exp);
        chkw(nm, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic chki(string nm, int act, int exp);
        chkw(nm, 128'(act), 128'(exp));
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n && cyc_n < NCYC) begin
            chkb("ack",  o_wb_ack, exp_ack[cyc_n]);
            chkb("err",  o_wb_err, exp_err[cyc_n]);
            chkb("busy", o_busy,   exp_busy[cyc_n]);
            chkw("dat",  o_wb_dat, exp_dat[cyc_n]);
            if (o_wb_ack) begin
                ack_cyc.push_back(cyc_n);
                last_rd = o_wb_dat;
            end
            if (o_wb_err) err_cnt++;
        end
    end

    function automatic bit in_rng(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(16 * DEPTH);
    endfunction

    function automatic logic [DL-1:0] line_of(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[DL+3:4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(logic [DL-1:0] idx, logic [127:0] d);
        i_ld_en  = 1'b1;
        i_ld_idx = idx;
        i_ld_dat = d;
        mmem[idx] = d;
        tick();
        i_ld_en = 1'b0;
    endtask

    // Schedule what a transfer accepted at edge 'a' must look like, and apply it to the model.
    task automatic expect_xfer(int a, logic [31:0] adr, logic [15:0] sel, logic we,
                               logic [127:0] d, logic col, logic [127:0] col_dat);
        int r;
        logic [DL-1:0] ln;
        r = a + WS;
        for (int i = 0; i <= WS; i++) exp_busy[a+i] = 1'b1;
        if (!in_rng(adr)) begin
            exp_err[r] = 1'b1;
        end else begin
            ln = line_of(adr);
            exp_ack[r] = 1'b1;
            if (!we) exp_dat[r] = mmem[ln];
            if (col) mmem[ln] = col_dat;
            if (we) begin
                for (int b = 0; b < 16; b++)
                    if (sel[b]) mmem[ln][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic xfer(logic [31:0] adr, logic [15:0] sel, logic we, logic [127:0] d,
                        logic col, logic [127:0] col_dat);
        int c;
        c = cyc_n;
        i_wb_adr = adr;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_dat = d;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        expect_xfer(c + 1, adr, sel, we, d, col, col_dat);
        repeat (WS) tick();
        if (col) begin
            i_ld_en  = 1'b1;
            i_ld_idx = line_of(adr);
            i_ld_dat = col_dat;
        end
        tick();
        i_ld_en  = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick();
    endtask

    localparam logic [127:0] PROG0 = 128'hF0801003_F0801003_F0801003_E3A01005;
    localparam logic [127:0] OLD3  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] OLD4  = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

    initial begin
        int c0, na, ne;
        logic [31:0]  ra;
        logic         rwe, rcol;
        logic [127:0] rd, rc;

        #1;
        chkb("rst_ack",  o_wb_ack, 1'b0);
        chkb("rst_err",  o_wb_err, 1'b0);
        chkb("rst_busy", o_busy,   1'b0);
        chkw("rst_dat",  o_wb_dat, 128'd0);
        #21 rst_n = 1'b1;
        tick();
        chk_on = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            preload(DL'(i), {$urandom, $urandom, $urandom, $urandom});

        // 1: preloaded program line read with two wait states
        preload(8'd0, PROG0);
        c0 = cyc_n;
        xfer(32'h0, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("t1_rdata", last_rd, PROG0);
        chki("t1_latency", ack_cyc[$] - (c0 + 1), 2);

        // 2: low-word byte-lane write over all-ones
        preload(8'd1, {128{1'b1}});
        xfer(32'h10, 16'h000F, 1'b1, 128'h11111111_22222222_33333333_DEADBEEF, 1'b0, '0);
        xfer(32'h10, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("t2_rdata", last_rd, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hDEADBEEF});

        // 3: out-of-range read and write terminate with err and leave memory alone
        ne = err_cnt;
        na = ack_cyc.size();
        xfer(32'h1000, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        xfer(32'h1000, 16'hFFFF, 1'b1, {4{32'h5A5A5A5A}}, 1'b0, '0);
        chki("t3_errs", err_cnt - ne, 2);
        chki("t3_noack", ack_cyc.size() - na, 0);
        xfer(32'h0, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("t3_line0", last_rd, PROG0);

        // 4: stb held across two reads, second accept only after RESP leaves
        na = ack_cyc.size();
        c0 = cyc_n;
        i_wb_adr = 32'h0;
        i_wb_sel = 16'hFFFF;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        expect_xfer(c0 + 1, 32'h0, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        expect_xfer(c0 + WS + 3, 32'h20, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        repeat (WS + 1) tick();
        i_wb_adr = 32'h20;
        repeat (WS + 2) tick();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick();
        tick();
        chki("t4_acks", ack_cyc.size() - na, 2);
        if (ack_cyc.size() - na == 2)
            chki("t4_spacing", ack_cyc[na+1] - ack_cyc[na], 4);

        // 5: cyc dropped in WAIT aborts the write
        preload(8'd3, OLD3);
        na = ack_cyc.size();
        c0 = cyc_n;
        i_wb_adr = 32'h30;
        i_wb_sel = 16'hFFFF;
        i_wb_we  = 1'b1;
        i_wb_dat = {4{32'hBADBAD00}};
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        exp_busy[c0 + 1] = 1'b1;
        tick();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick();
        tick();
        chki("t5_noack", ack_cyc.size() - na, 0);
        chkb("t5_busy", o_busy, 1'b0);
        xfer(32'h30, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("t5_line3", last_rd, OLD3);

        // 6: asynchronous reset in WAIT drops the pending write
        preload(8'd4, OLD4);
        c0 = cyc_n;
        i_wb_adr = 32'h40;
        i_wb_sel = 16'hFFFF;
        i_wb_we  = 1'b1;
        i_wb_dat = {4{32'h77777777}};
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        exp_busy[c0 + 1] = 1'b1;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chkb("t6_busy", o_busy,   1'b0);
        chkb("t6_ack",  o_wb_ack, 1'b0);
        chkb("t6_err",  o_wb_err, 1'b0);
        chkw("t6_dat",  o_wb_dat, 128'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        for (int i = 0; i < WS + 8; i++) begin
            exp_busy[cyc_n + i] = 1'b0;
            exp_ack[cyc_n + i]  = 1'b0;
            exp_err[cyc_n + i]  = 1'b0;
            exp_dat[cyc_n + i]  = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xfer(32'h40, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("t6_line4", last_rd, OLD4);

        // preload colliding with a bus write: bus owns selected lanes, preload the rest
        xfer(32'h50, 16'h00FF, 1'b1, {64'h0, 64'h1122334455667788}, 1'b1,
             {64'hAAAABBBBCCCCDDDD, 64'hEEEEEEEEEEEEEEEE});
        xfer(32'h50, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        chkw("collide", last_rd, {64'hAAAABBBBCCCCDDDD, 64'h1122334455667788});

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       ra = 32'h1000 + 32'($urandom_range(0, 32'h0FFF));
                1:       ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: ra = {20'h0, 8'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15))};
            endcase
            rwe  = 1'($urandom_range(0, 1));
            rd   = {$urandom, $urandom, $urandom, $urandom};
            rc   = {$urandom, $urandom, $urandom, $urandom};
            rcol = in_rng(ra) && ($urandom_range(0, 3) == 0);
            xfer(ra, 16'($urandom), rwe, rd, rcol, rc);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
